temp_sample_sched: RTL and testbench

//  Periodic sample scheduler for the I2C temperature datapath. Paces read requests to the I2C

---
 rtl/temp_sample_sched.sv | 261 ++++++++++++++++++++++++++
 tb/tb_temp_sample_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_sched.sv
// temp_sample_sched
//   Periodic sample scheduler for the I2C temperature datapath. A free-running
//   period counter issues a tick every PERIOD_CYC clocks. Each tick launches one
//   read request to the I2C master. NACK and timeout faults are counted, and good
//   readings feed a 2^AVG_LOG2-deep moving average.
//
//   Optional feature: define TEMP_MINMAX_EN to build the raw-sample min/max
//   trackers. Without it, min_c/max_c are the constants 8'hFF/8'h00.
//
// Ports
//   clk_100MHz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   i2c_start    out  read request to the I2C master (registered)
//   i2c_busy     in   master transaction in progress
//   i2c_done     in   1-cycle pulse, i2c_data / i2c_ack_err valid
//   i2c_ack_err  in   NACK seen during the transaction (qualified by i2c_done)
//   i2c_data     in   raw Celsius byte, unsigned
//   clr          in   1-cycle clear of fault, overrun, error count, min/max
//   temp_c       out  averaged Celsius
//   temp_upd     out  1-cycle pulse when temp_c changes
//   have_data    out  at least one good sample since reset
//   fault        out  sticky, MAX_ERR consecutive errors
//   overrun      out  sticky, tick arrived while a transaction was in flight
//   min_c/max_c  out  raw-sample extremes (TEMP_MINMAX_EN), else FF/00
//
// Handshake with the I2C master: i2c_start rises the cycle after a tick and is
// held until i2c_busy is sampled high; it drops on that same edge. The result is
// taken only from a single-cycle i2c_done pulse seen while waiting. A done pulse
// in any other state, including one that arrives after a timeout or a reset, is
// ignored.

module temp_sample_sched #(
  parameter int PERIOD_CYC  = 25_000_000,
  parameter int TIMEOUT_CYC = 200_000,
  parameter int AVG_LOG2    = 2,
  parameter int MAX_ERR     = 3
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  output logic       i2c_start,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  input  logic [7:0] i2c_data,
  input  logic       clr,
  output logic [7:0] temp_c,
  output logic       temp_upd,
  output logic       have_data,
  output logic       fault,
  output logic       overrun,
  output logic [7:0] min_c,
  output logic [7:0] max_c
);

  localparam int PER_W = $clog2(PERIOD_CYC);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = 8 + AVG_LOG2;
  localparam int ERR_W = $clog2(MAX_ERR + 1);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(MAX_ERR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t            state;
  logic [PER_W-1:0]  per_cnt;
  logic              tick;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [7:0]        sample;
  logic [ERR_W-1:0]  err_cnt;
  logic [ERR_W-1:0]  err_inc;

  logic [7:0]        avg_buf [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [SUM_W-1:0]  sum;
  logic              primed;
  logic              calc_done;
  logic [7:0]        avg_now;

  // ---------------------------------------------------------------------------
  // Tick generator. The tick is registered, so it is high for the one cycle
  // in which the counter has just wrapped to 0. The first tick therefore
  // appears PERIOD_CYC clocks after reset release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= (per_cnt == PER_LAST);
      if (per_cnt == PER_LAST) per_cnt <= '0;
      else                     per_cnt <= per_cnt + 1'b1;
    end
  end

  // The error count saturates at MAX_ERR, so repeated errors keep fault set
  // without wrapping the counter.
  assign err_inc = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // Request FSM, with its registered outputs and sticky status flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      i2c_start <= 1'b0;
      sample    <= 8'h00;
      err_cnt   <= '0;
      fault     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_REQ;
            i2c_start <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (i2c_busy) begin
            state     <= S_WAIT;
            i2c_start <= 1'b0;
            tmo_cnt   <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_ERROR;
            i2c_start <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i2c_done) begin
            if (i2c_ack_err) begin
              state <= S_ERROR;
            end else begin
              state  <= S_UPDATE;
              sample <= i2c_data;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_UPDATE: state <= S_IDLE;
        S_ERROR:  state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          i2c_start <= 1'b0;
        end
      endcase

      // clr takes priority over every flag update in the same cycle,
      // including a coincident tick.
      if (clr) begin
        err_cnt <= '0;
        fault   <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (tick && (state != S_IDLE)) overrun <= 1'b1;
        if (state == S_UPDATE) begin
          err_cnt <= '0;
        end else if (state == S_ERROR) begin
          err_cnt <= err_inc;
          if (err_inc == ERR_MAX) fault <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moving average. The first good sample fills every entry, so the average
  // starts at the true value instead of ramping up from zero. After that the
  // running sum swaps the oldest entry for the newest one. The sum is
  // 8+AVG_LOG2 bits wide, and the intermediate wrap cancels out.
  // ---------------------------------------------------------------------------
  assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  assign avg_now  = sum[SUM_W-1 -: 8];

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) avg_buf[i] <= 8'h00;
      ptr       <= '0;
      sum       <= '0;
      primed    <= 1'b0;
      calc_done <= 1'b0;
    end else begin
      calc_done <= 1'b0;
      if (state == S_UPDATE) begin
        calc_done <= 1'b1;
        primed    <= 1'b1;
        ptr       <= ptr_next;
        if (!primed) begin
          for (int i = 0; i < DEPTH; i++) avg_buf[i] <= sample;
          sum <= SUM_W'(sample) << AVG_LOG2;
        end else begin
          avg_buf[ptr] <= sample;
          sum          <= sum + SUM_W'(sample) - SUM_W'(avg_buf[ptr]);
        end
      end
    end
  end

  // Output stage: the result appears two clocks after i2c_done is sampled.
  // temp_upd fires only when the visible value actually changes.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      temp_c    <= 8'h00;
      temp_upd  <= 1'b0;
      have_data <= 1'b0;
    end else begin
      temp_upd <= 1'b0;
      if (calc_done) begin
        temp_c    <= avg_now;
        temp_upd  <= (avg_now != temp_c);
        have_data <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw-sample extremes.
  // ---------------------------------------------------------------------------
`ifdef TEMP_MINMAX_EN
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      min_c <= 8'hFF;
      max_c <= 8'h00;
    end else if (clr) begin
      // A clear that lands on an update restarts tracking from that sample.
      if (state == S_UPDATE) begin
        min_c <= sample;
        max_c <= sample;
      end else begin
        min_c <= 8'hFF;
        max_c <= 8'h00;
      end
    end else if (state == S_UPDATE) begin
      if (sample < min_c) min_c <= sample;
      if (sample > max_c) max_c <= sample;
    end
  end
`else
  assign min_c = 8'hFF;
  assign max_c = 8'h00;
`endif

endmodule

// File: tb/tb_temp_sample_sched.sv
// Bench for temp_sample_sched with a short period (PERIOD 100, TIMEOUT 20,
// 4-deep average, MAX_ERR 3). A second instance with a long timeout
// (TIMEOUT 200) produces a transaction that outlives a tick, which exercises
// overrun. The second instance stays in reset until its own test runs.

module tb_temp_sample_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i2c_start;
  logic       i2c_busy = 1'b0;
  logic       i2c_done = 1'b0;
  logic       i2c_ack_err = 1'b0;
  logic [7:0] i2c_data = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] temp_c;
  logic       temp_upd;
  logic       have_data;
  logic       fault;
  logic       overrun;
  logic [7:0] min_c;
  logic [7:0] max_c;

  logic       rst2_n = 1'b0;
  logic       start2;
  logic       busy2 = 1'b0;
  logic       done2 = 1'b0;
  logic       ack2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       clr2 = 1'b0;
  logic [7:0] temp2;
  logic       upd2;
  logic       have2;
  logic       fault2;
  logic       overrun2;
  logic [7:0] min2;
  logic [7:0] max2;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] cur_temp = 8'h00;
  logic [7:0] mdl_min = 8'hFF;
  logic [7:0] mdl_max = 8'h00;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  temp_sample_sched #(
    .PERIOD_CYC(100), .TIMEOUT_CYC(20), .AVG_LOG2(2), .MAX_ERR(3)
  ) dut (
    .clk_100MHz(clk), .rst_n(rst_n), .i2c_start(i2c_start), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err), .i2c_data(i2c_data), .clr(clr),
    .temp_c(temp_c), .temp_upd(temp_upd), .have_data(have_data), .fault(fault),
    .overrun(overrun), .min_c(min_c), .max_c(max_c)
  );

  temp_sample_sched #(
    .PERIOD_CYC(100), .TIMEOUT_CYC(200), .AVG_LOG2(2), .MAX_ERR(3)
  ) dut2 (
    .clk_100MHz(clk), .rst_n(rst2_n), .i2c_start(start2), .i2c_busy(busy2),
    .i2c_done(done2), .i2c_ack_err(ack2), .i2c_data(data2), .clr(clr2),
    .temp_c(temp2), .temp_upd(upd2), .have_data(have2), .fault(fault2),
    .overrun(overrun2), .min_c(min2), .max_c(max2)
  );

  typedef struct {
    logic       clr_first;
    logic [7:0] data;
    logic       ack;
    logic [7:0] exp_temp;
    logic       exp_upd;
    logic       exp_fault;
  } vec_t;

  vec_t vecs [12];

  // Scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_min();
`ifdef TEMP_MINMAX_EN
    return int'(mdl_min);
`else
    return 255;
`endif
  endfunction

  function automatic int exp_max();
`ifdef TEMP_MINMAX_EN
    return int'(mdl_max);
`else
    return 0;
`endif
  endfunction

  // Driver tasks (all drive #1 after a rising edge)
  task automatic wait_start(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i2c_start) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_start_seen"}, (at >= 0) ? 1 : 0, 1);
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mdl_min = 8'hFF;
    mdl_max = 8'h00;
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_min"}, min_c, exp_min());
    chk({tag, "_max"}, max_c, exp_max());
  endtask

  // One transaction: busy 2 clocks after start, done 10 clocks after busy.
  task automatic xact(input string tag, input logic [7:0] d, input logic ack,
                      input logic [7:0] exp_temp, input logic exp_upd,
                      input logic exp_fault, output int at);
    wait_start(tag, at);
    repeat (2) @(posedge clk);
    #1 i2c_busy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    i2c_done = 1'b1; i2c_data = d; i2c_ack_err = ack;
    @(posedge clk); #1;
    i2c_done = 1'b0; i2c_busy = 1'b0; i2c_ack_err = 1'b0;
    if (!ack) begin
      if (d < mdl_min) mdl_min = d;
      if (d > mdl_max) mdl_max = d;
    end
    @(posedge clk); #1;
    chk({tag, "_e1_temp"}, temp_c, cur_temp);
    chk({tag, "_e1_upd"}, temp_upd, 0);
    chk({tag, "_e1_start"}, i2c_start, 0);
    @(posedge clk); #1;
    chk({tag, "_temp"}, temp_c, exp_temp);
    chk({tag, "_upd"}, temp_upd, exp_upd);
    chk({tag, "_fault"}, fault, exp_fault);
    chk({tag, "_have"}, have_data, 1);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_min"}, min_c, exp_min());
    chk({tag, "_max"}, max_c, exp_max());
    @(posedge clk); #1;
    chk({tag, "_e3_upd"}, temp_upd, 0);
    cur_temp = exp_temp;
  endtask

  initial begin
    int at;
    int base;
    int base2;
    int n_hi;

    //                clr   data   ack   temp   upd   fault
    vecs[0]  = '{1'b0, 8'd25, 1'b0, 8'd25, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'd29, 1'b0, 8'd26, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd29, 1'b0, 8'd27, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'd29, 1'b0, 8'd28, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'd77, 1'b1, 8'd28, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'd77, 1'b1, 8'd28, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd77, 1'b1, 8'd28, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd33, 1'b0, 8'd30, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'd10, 1'b0, 8'd25, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'd41, 1'b0, 8'd28, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'd41, 1'b0, 8'd31, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'd33, 1'b0, 8'd31, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", i2c_start, 0);
    chk("rst_temp", temp_c, 0);
    chk("rst_upd", temp_upd, 0);
    chk("rst_have", have_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_min", min_c, 255);
    chk("rst_max", max_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr_first) pulse_clr($sformatf("r%0d_clr", i));
      xact($sformatf("r%0d", i), vecs[i].data, vecs[i].ack, vecs[i].exp_temp,
           vecs[i].exp_upd, vecs[i].exp_fault, at);
      if (i == 0) chk("first_start_cyc", at - base, 101);
    end

    // REQ timeout: start held exactly TIMEOUT_CYC clocks, error 1
    wait_start("req_tmo", at);
    n_hi = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i2c_start) n_hi++;
    end
    chk("req_tmo_start_len", n_hi, 20);
    chk("req_tmo_fault", fault, 0);
    chk("req_tmo_temp", temp_c, 31);

    // WAIT timeout (busy, never done), error 2; then a late done is ignored
    wait_start("wait_tmo", at);
    repeat (2) @(posedge clk);
    #1 i2c_busy = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("wait_tmo_start", i2c_start, 0);
    chk("wait_tmo_fault", fault, 0);
    i2c_busy = 1'b0;
    i2c_done = 1'b1; i2c_data = 8'd99;
    @(posedge clk); #1;
    i2c_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_done_temp", temp_c, 31);
    chk("late_done_upd", temp_upd, 0);

    // Third consecutive error sets fault; a good sample leaves it sticky
    xact("err3", 8'd77, 1'b1, 8'd31, 1'b0, 1'b1, at);
    xact("sticky", 8'd33, 1'b0, 8'd37, 1'b1, 1'b1, at);
    pulse_clr("clr2");

    // Reset mid-transaction: start drops without a clock edge
    wait_start("mid_rst", at);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", i2c_start, 0);
    chk("mid_rst_temp", temp_c, 0);
    chk("mid_rst_have", have_data, 0);
    chk("mid_rst_min", min_c, 255);
    @(negedge clk);
    rst_n = 1'b1;

    // Overrun on the long-timeout instance
    @(negedge clk);
    rst2_n = 1'b1;
    base2 = cyc;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (start2) begin
        at = cyc;
        break;
      end
    end
    chk("ovr_first_start", at - base2, 101);
    repeat (2) @(posedge clk);
    #1 busy2 = 1'b1;
    repeat (97) @(posedge clk);
    #1 chk("ovr_before_tick", overrun2, 0);
    @(posedge clk);
    #1 chk("ovr_after_tick", overrun2, 1);
    repeat (52) @(posedge clk);
    #1;
    done2 = 1'b1; data2 = 8'd50;
    @(posedge clk); #1;
    done2 = 1'b0; busy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_s1_temp", temp2, 50);
    chk("ovr_s1_upd", upd2, 1);
    chk("ovr_s1_have", have2, 1);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (start2) begin
        at = cyc;
        break;
      end
    end
    chk("ovr_next_start", at - base2, 301);
    repeat (2) @(posedge clk);
    #1 busy2 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    done2 = 1'b1; data2 = 8'd60;
    @(posedge clk); #1;
    done2 = 1'b0; busy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_s2_temp", temp2, 52);
    chk("ovr_s2_sticky", overrun2, 1);
    chk("ovr_s2_fault", fault2, 0);
    clr2 = 1'b1;
    @(posedge clk); #1;
    clr2 = 1'b0;
    chk("ovr_clr", overrun2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
